lia_ctrl_regbank: RTL
=====================

// Module: lia_ctrl_regbank
// PURPOSE
//  Parametrised Avalon-MM control/status register bank for N_CH lock-in channels; replaces loose PIO exports.
//  Holds per-channel DDS phase increment/offset in shadow registers; all channels commit atomically on a sample tick.
//  Snapshots every channel's X/Y on a sample tick for coherent readback; also drives gain_ctrl, dac_gain, dac_div.
// PARAMETERS
//  N_CH     8   lock-in channel count, 1..16
//  PHASE_W  20  phase increment/offset width, <=32
//  LIA_W    16  signed X/Y result width, <=32
//  GAIN_W   6   gain_ctrl width
//  DAC_W    8   dac_gain / dac_div width
//  ADDR_W   7   word address width, must satisfy 2**ADDR_W >= 8+4*N_CH
// PORTS
//  clk_clk             in   1             system clock
//  reset_reset         in   1             synchronous, active-high reset
//  avs_address         in   ADDR_W        word address
//  avs_read            in   1             read strobe
//  avs_write           in   1             write strobe
//  avs_writedata       in   32            write data
//  avs_readdata        out  32            read data
//  avs_readdatavalid   out  1             read data valid
//  sample_tick         in   1             1-cycle pulse per lock-in output sample
//  lia_x_in            in   N_CH*LIA_W    packed signed X, ch0 in LSBs
//  lia_y_in            in   N_CH*LIA_W    packed signed Y, ch0 in LSBs
//  phase_incr_out      out  N_CH*PHASE_W  active phase increments, ch0 in LSBs
//  phase_offs_out      out  N_CH*PHASE_W  active phase offsets
//  gain_ctrl_export    out  GAIN_W        front-end gain
//  dac_gain_export     out  DAC_W         DAC gain
//  dac_div_export      out  DAC_W         DAC clock divider
//  commit_pulse        out  1             1 cycle when active phase regs update
// BEHAVIOUR
//  Map (word): 0 CTRL W1 [0]=COMMIT [1]=SNAP [2]=IMMEDIATE; 1 STATUS RO [0]=commit_pend [1]=snap_pend [2]=snap_valid;
//   2 GAIN_CTRL; 3 DAC_GAIN; 4 DAC_DIV; 8+4c+0 INCR_SH[c]; +1 OFFS_SH[c]; +2 X_SNAP[c] RO; +3 Y_SNAP[c] RO.
//  Reset: all outputs, shadows, snapshots, pend/valid flags = 0; readdatavalid = 0.
//  Read: readdata/readdatavalid registered, latency exactly 1 cycle; one read per cycle, no waitrequest.
//  Unmapped/CTRL reads return 0; writes to RO/unmapped ignored; write data truncated to field width.
//  Reads zero-extend R/W fields; X/Y snapshots sign-extended to 32 b. CTRL reads 0 (self-clearing).
//  Read and write same cycle: both performed; read returns pre-write value.
//  Commit FSM IDLE->PEND on CTRL write with COMMIT=1 and IMMEDIATE=0; PEND->IDLE on sample_tick: active<=shadow, commit_pulse=1.
//  COMMIT=1 with IMMEDIATE=1: apply on next clock regardless of tick/state, pulse 1 cycle, state->IDLE.
//  COMMIT while PEND: stays PEND (no double apply). Shadow write in apply cycle: apply uses pre-write shadow.
//  Commit request coinciding with sample_tick while IDLE: enters PEND, applies on the following tick.
//  Snap FSM identical (no immediate): SNAP -> snap_pend=1, snap_valid=0; next tick latches all X/Y, snap_valid=1.
//  GAIN_CTRL/DAC_GAIN/DAC_DIV take effect the cycle after the write (no shadowing).
//  reset_reset mid-PEND: FSMs to IDLE, no pulse, active regs cleared to 0.
// STRUCTURE
//  lia_regs_pkg: address constants (CTRL, STATUS, GAIN, DAC_GAIN, DAC_DIV, CH_BASE=8, CH_STRIDE=4), CTRL/STATUS bit indices, fsm state typedef.
//  Sub-module lia_tick_fsm (IDLE/PEND, req, immediate, tick -> fire, pend): instantiated for commit and snapshot.
//  Channel decode via generate loop over N_CH; readback mux registered.
// TESTING
//  Reset then read all mapped addrs -> every readdata 0, readdatavalid exactly 1 cycle after each read.
//  Write INCR_SH[3]=0x12345, CTRL=0x1, no tick 20 cycles -> phase_incr_out ch3 stays 0, STATUS=0x1; tick -> ch3=0x12345, commit_pulse 1 cycle, STATUS=0.
//  Write OFFS_SH[0]=0xFFFFFFFF, CTRL=0x5 -> next cycle ch0 offs=0xFFFFF (PHASE_W=20) without tick; readback 0x000FFFFF.
//  lia_x_in ch7=0x8000, CTRL=0x2, tick, then change input -> X_SNAP[7] reads 0xFFFF8000, STATUS[2]=1.
//  COMMIT twice then tick with shadow write same cycle -> single commit_pulse, old shadow applied, new shadow applied on next commit.
//  Assert reset_reset while PEND -> outputs 0, STATUS 0, later tick produces no commit_pulse.

Source files
------------

// File: rtl/lia_regs_pkg.sv
// Register map, control/status bit positions and FSM state type for the lock-in register bank.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package lia_regs_pkg;

  // Word addresses of the global registers
  localparam int ADDR_CTRL     = 0;
  localparam int ADDR_STATUS   = 1;
  localparam int ADDR_GAIN     = 2;
  localparam int ADDR_DAC_GAIN = 3;
  localparam int ADDR_DAC_DIV  = 4;

  // Per-channel block: CH_BASE + CH_STRIDE*c + offset
  localparam int CH_BASE   = 8;
  localparam int CH_STRIDE = 4;
  localparam int CH_INCR   = 0;
  localparam int CH_OFFS   = 1;
  localparam int CH_X      = 2;
  localparam int CH_Y      = 3;

  // CTRL bits (write-one, self-clearing)
  localparam int CTRL_COMMIT    = 0;
  localparam int CTRL_SNAP      = 1;
  localparam int CTRL_IMMEDIATE = 2;

  // STATUS bits
  localparam int STAT_COMMIT_PEND = 0;
  localparam int STAT_SNAP_PEND   = 1;
  localparam int STAT_SNAP_VALID  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } tick_state_t;

endpackage

// File: rtl/lia_tick_fsm.sv
// Defers a request until the next sample tick (or fires at once when immediate), exposing a pending flag.
// Latency: fire is combinational in the cycle of the tick (or immediate request); pend follows one cycle after req.
// Backpressure: none; requests arriving while pending merge into the outstanding one.
module lia_tick_fsm
  import lia_regs_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic immediate,
  input  logic tick,
  output logic fire,
  output logic pend
);

  tick_state_t state, state_nxt;

  // State register, synchronous reset back to idle
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and fire decode; an immediate request overrides any pending one
  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    pend      = (state == ST_PEND);
    if (req && immediate) begin
      fire      = 1'b1;
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (req) state_nxt = ST_PEND;
        ST_PEND: if (tick) begin
          fire      = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lia_ctrl_regbank.sv
// Avalon-MM register bank: shadowed per-channel DDS phase regs committed on a tick, X/Y snapshots, gain/DAC controls.
// Latency: read data 1 cycle after avs_read; direct controls update the cycle after the write; commits land on the tick edge.
// Backpressure: none; one read and/or one write accepted every cycle, no waitrequest.
module lia_ctrl_regbank #(
  parameter int N_CH    = 8,
  parameter int PHASE_W = 20,
  parameter int LIA_W   = 16,
  parameter int GAIN_W  = 6,
  parameter int DAC_W   = 8,
  parameter int ADDR_W  = 7
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset,
  input  logic [ADDR_W-1:0]         avs_address,
  input  logic                      avs_read,
  input  logic                      avs_write,
  input  logic [31:0]               avs_writedata,
  output logic [31:0]               avs_readdata,
  output logic                      avs_readdatavalid,
  input  logic                      sample_tick,
  input  logic [N_CH*LIA_W-1:0]     lia_x_in,
  input  logic [N_CH*LIA_W-1:0]     lia_y_in,
  output logic [N_CH*PHASE_W-1:0]   phase_incr_out,
  output logic [N_CH*PHASE_W-1:0]   phase_offs_out,
  output logic [GAIN_W-1:0]         gain_ctrl_export,
  output logic [DAC_W-1:0]          dac_gain_export,
  output logic [DAC_W-1:0]          dac_div_export,
  output logic                      commit_pulse
);

  import lia_regs_pkg::*;

  logic [N_CH-1:0][PHASE_W-1:0] incr_sh, offs_sh, incr_act, offs_act;
  logic [N_CH-1:0][LIA_W-1:0]   x_snap, y_snap;
  logic [GAIN_W-1:0]            gain_q;
  logic [DAC_W-1:0]             dac_gain_q, dac_div_q;
  logic                         snap_valid;

  logic wr_ctrl, commit_req, snap_req;
  logic commit_fire, commit_pend, snap_fire, snap_pend;
  logic [N_CH-1:0] wr_incr, wr_offs;
  logic [31:0] ch_rd [N_CH];
  logic [31:0] rd_mux;
  logic        unused_wdata;

  // Upper write-data bits beyond each field width are intentionally dropped
  assign unused_wdata = ^avs_writedata;

  assign wr_ctrl    = avs_write && (avs_address == ADDR_W'(ADDR_CTRL));
  assign commit_req = wr_ctrl && avs_writedata[CTRL_COMMIT];
  assign snap_req   = wr_ctrl && avs_writedata[CTRL_SNAP];

  lia_tick_fsm u_commit_fsm (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .req       (commit_req),
    .immediate (avs_writedata[CTRL_IMMEDIATE]),
    .tick      (sample_tick),
    .fire      (commit_fire),
    .pend      (commit_pend)
  );

  lia_tick_fsm u_snap_fsm (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .req       (snap_req),
    .immediate (1'b0),
    .tick      (sample_tick),
    .fire      (snap_fire),
    .pend      (snap_pend)
  );

  // Per-channel address decode: write enables and a zero-unless-hit read word
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    localparam int BASE = CH_BASE + CH_STRIDE * c;
    logic hit_incr, hit_offs, hit_x, hit_y;
    assign hit_incr   = (avs_address == ADDR_W'(BASE + CH_INCR));
    assign hit_offs   = (avs_address == ADDR_W'(BASE + CH_OFFS));
    assign hit_x      = (avs_address == ADDR_W'(BASE + CH_X));
    assign hit_y      = (avs_address == ADDR_W'(BASE + CH_Y));
    assign wr_incr[c] = avs_write && hit_incr;
    assign wr_offs[c] = avs_write && hit_offs;
    assign ch_rd[c]   = hit_incr ? 32'(incr_sh[c]) :
                        hit_offs ? 32'(offs_sh[c]) :
                        hit_x    ? 32'(signed'(x_snap[c])) :
                        hit_y    ? 32'(signed'(y_snap[c])) : 32'd0;
  end

  // Register file: shadows, active phase regs (loaded from pre-write shadows), snapshots, direct controls
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      incr_sh      <= '0;
      offs_sh      <= '0;
      incr_act     <= '0;
      offs_act     <= '0;
      x_snap       <= '0;
      y_snap       <= '0;
      gain_q       <= '0;
      dac_gain_q   <= '0;
      dac_div_q    <= '0;
      snap_valid   <= 1'b0;
      commit_pulse <= 1'b0;
    end else begin
      if (avs_write && avs_address == ADDR_W'(ADDR_GAIN))     gain_q     <= avs_writedata[GAIN_W-1:0];
      if (avs_write && avs_address == ADDR_W'(ADDR_DAC_GAIN)) dac_gain_q <= avs_writedata[DAC_W-1:0];
      if (avs_write && avs_address == ADDR_W'(ADDR_DAC_DIV))  dac_div_q  <= avs_writedata[DAC_W-1:0];
      for (int c = 0; c < N_CH; c++) begin
        if (wr_incr[c]) incr_sh[c] <= avs_writedata[PHASE_W-1:0];
        if (wr_offs[c]) offs_sh[c] <= avs_writedata[PHASE_W-1:0];
      end
      if (commit_fire) begin
        incr_act <= incr_sh;
        offs_act <= offs_sh;
      end
      commit_pulse <= commit_fire;
      if (snap_fire) begin
        x_snap     <= lia_x_in;
        y_snap     <= lia_y_in;
        snap_valid <= 1'b1;
      end else if (snap_req) begin
        snap_valid <= 1'b0;
      end
    end
  end

  // Readback mux; CTRL and unmapped addresses fall through to zero
  always_comb begin
    rd_mux = 32'd0;
    if (avs_address == ADDR_W'(ADDR_STATUS)) begin
      rd_mux[STAT_COMMIT_PEND] = commit_pend;
      rd_mux[STAT_SNAP_PEND]   = snap_pend;
      rd_mux[STAT_SNAP_VALID]  = snap_valid;
    end else if (avs_address == ADDR_W'(ADDR_GAIN)) begin
      rd_mux = 32'(gain_q);
    end else if (avs_address == ADDR_W'(ADDR_DAC_GAIN)) begin
      rd_mux = 32'(dac_gain_q);
    end else if (avs_address == ADDR_W'(ADDR_DAC_DIV)) begin
      rd_mux = 32'(dac_div_q);
    end
    for (int c = 0; c < N_CH; c++) rd_mux = rd_mux | ch_rd[c];
  end

  // Registered read response, exactly one cycle after the strobe
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      avs_readdata      <= 32'd0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read;
      avs_readdata      <= avs_read ? rd_mux : 32'd0;
    end
  end

  assign phase_incr_out   = incr_act;
  assign phase_offs_out   = offs_act;
  assign gain_ctrl_export = gain_q;
  assign dac_gain_export  = dac_gain_q;
  assign dac_div_export   = dac_div_q;

endmodule
